dsp_mac_sequencer: RTL and testbench

Job-level controller that sequences one DSP48A1 slice as a multiply-accumulate engine. It accepts a job length, streams operand pairs into the slice through a valid/ready handshake, and drives OPMODE cycle-by-cycle so that P accumulates exactly the job's products. It returns the 48-bit sum on a result handshake. It sits between an operand source (FIR/dot-product front end) and the DSP slice.

---
 rtl/dsp_mac_pkg.sv | 25 ++
 rtl/dsp_mac_tag_pipe.sv | 37 +++
 rtl/dsp_mac_sequencer.sv | 136 +++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_pkg;

  // OPMODE values presented to the slice; bits 7:4 stay 0 (add, no pre-adder, no carry-in).
  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0: start a new sum
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P: accumulate
  localparam logic [7:0] OPM_HOLD = 8'h08;  // X=0, Z=P: P holds through bubbles

  // Cycles from an operand fire until P holds that element's accumulated sum.
  localparam int unsigned PIPE_LAT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_mac_tag_pipe.sv
// Shift register of element tags that tracks each operand through the slice pipeline.
module dsp_mac_tag_pipe
  import dsp_mac_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t s1_o,
  output tag_t s3_o
);

  tag_t pipe_q [PIPE_LAT];
  tag_t pipe_d [PIPE_LAT];

  // Next stage contents: new tag enters stage 1, older tags shift one stage down.
  always_comb begin
    pipe_d[0] = tag_i;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign s1_o = pipe_q[0];
  assign s3_o = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Job-level controller driving one DSP48A1 slice as a multiply-accumulate engine.
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [47:0]      res_data_q, res_data_d;
  logic             op_ready_q, op_ready_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;

  logic fire;
  logic is_last;
  tag_t tag_in;
  tag_t s1;
  tag_t s3;

  assign fire    = op_valid && op_ready_q;
  assign is_last = (cnt_q == (len_q - CNT_W'(1)));

  // Tag for the element entering the slice this cycle.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = fire;
    tag_in.first = fire && (cnt_q == '0);
    tag_in.last  = fire && is_last;
  end

  dsp_mac_tag_pipe u_tag_pipe (
    .clk_i (CLK),
    .rst_i (RST),
    .tag_i (tag_in),
    .s1_o  (s1),
    .s3_o  (s3)
  );

  // Job FSM next state; outputs are decoded from the next state so they come out registered.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            res_data_d = '0;
            state_d    = StDone;
          end
        end
      end
      StRun: begin
        if (fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_last) state_d = StDrain;
        end
      end
      StDrain: begin
        // P holds the full sum once the last element's tag reaches the final stage.
        if (s3.valid && s3.last) begin
          res_data_d = dsp_p;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    op_ready_d  = (state_d == StRun);
    busy_d      = (state_d != StIdle);
    res_valid_d = (state_d == StDone);
  end

  // FSM and job registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  // OPMODE is registered inside the slice, so it is driven one cycle after the fire.
  always_comb begin
    dsp_opmode = OPM_HOLD;
    if (s1.valid) dsp_opmode = s1.first ? OPM_LOAD : OPM_ACC;
  end

  // Zero operands outside a fire so bubbles never leak stale products into M.
  assign dsp_a = fire ? op_a : '0;
  assign dsp_b = fire ? op_b : '0;

  assign op_ready  = op_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: reference DSP48A1 slice plus a job-level behavioural model.
module tb_dsp_mac_sequencer;

  localparam int unsigned CNT_W = 10;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             op_valid = 1'b0;
  logic [17:0]      op_a = '0;
  logic [17:0]      op_b = '0;
  logic             res_ready = 1'b0;
  logic             busy, op_ready, res_valid;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p, res_data;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  function automatic logic [47:0] prod48(input logic [17:0] a, input logic [17:0] b);
    logic signed [35:0] p;
    p = $signed(a) * $signed(b);
    return {{12{p[35]}}, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference slice: A1/B1 regs, M reg, OPMODE reg, P reg.
  logic [17:0] a1_r = '0, b1_r = '0;
  logic [47:0] m_r = '0, p_r = '0;
  logic [7:0]  opm_r = '0;
  always @(posedge CLK) begin
    if (RST) begin
      a1_r <= '0; b1_r <= '0; m_r <= '0; p_r <= '0; opm_r <= '0;
    end else begin
      a1_r  <= dsp_a;
      b1_r  <= dsp_b;
      m_r   <= prod48(a1_r, b1_r);
      opm_r <= dsp_opmode;
      p_r   <= ((opm_r[1:0] == 2'b01) ? m_r : 48'h0) + ((opm_r[3:2] == 2'b10) ? p_r : 48'h0);
    end
  end
  assign dsp_p = p_r;

  // Job-level model state.
  bit          m_active = 0;
  int          m_len = 0, m_acc = 0;
  logic [47:0] m_sum = '0, m_resreg = '0;
  longint      m_res_cyc = 64'h7fff_ffff;
  longint      m_job_start = 0;
  bit          m_prev_fire = 0, m_prev_first = 0;
  longint      cyc = 0;
  bit          rv_prev = 0;
  longint      last_lat = -1;

  // Compare outputs against the model each cycle, then advance the model across the next edge.
  always @(negedge CLK) begin : model
    bit          e_ready, e_rv, fire, was_active;
    logic [7:0]  e_opm;
    e_ready = m_active && (m_acc < m_len);
    e_rv    = m_active && (cyc >= m_res_cyc);
    fire    = op_valid && e_ready;
    e_opm   = m_prev_fire ? (m_prev_first ? 8'h01 : 8'h09) : 8'h08;
    chk("busy", busy, m_active);
    chk("op_ready", op_ready, e_ready);
    chk("res_valid", res_valid, e_rv);
    chk("res_data", res_data, m_resreg);
    chk("dsp_a", dsp_a, fire ? op_a : 18'h0);
    chk("dsp_b", dsp_b, fire ? op_b : 18'h0);
    chk("dsp_opmode", dsp_opmode, e_opm);
    if (res_valid === 1'b1 && !rv_prev) last_lat = cyc - m_job_start;
    rv_prev = (res_valid === 1'b1);
    if (RST) begin
      m_active = 0; m_acc = 0; m_len = 0; m_sum = '0; m_resreg = '0;
      m_res_cyc = 64'h7fff_ffff; m_prev_fire = 0; m_prev_first = 0;
    end else begin
      was_active = m_active;
      if (e_rv && res_ready) m_active = 0;
      if (!was_active && start) begin
        m_active = 1; m_len = int'(len); m_acc = 0; m_sum = '0; m_job_start = cyc;
        m_res_cyc = (len == '0) ? cyc + 1 : 64'h7fff_ffff;
      end
      m_prev_fire  = fire;
      m_prev_first = fire && (m_acc == 0);
      if (fire) begin
        m_sum = m_sum + prod48(op_a, op_b);
        m_acc++;
        if (m_acc == m_len) m_res_cyc = cyc + 4;
      end
      if (m_active && (cyc + 1 == m_res_cyc)) m_resreg = m_sum;
    end
    cyc++;
  end

  // Stimulus helpers.
  logic [17:0] va [16];
  logic [17:0] vb [16];
  int          vmode = 0;  // 0 full rate, 1 fixed pattern, 2 random
  bit          pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input int n);
    start = 1'b1;
    len   = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    int  i = 0, k = 0;
    bit  f;
    while (i < n && k < 2000) begin
      case (vmode)
        0:       op_valid = 1'b1;
        1:       op_valid = pat[k % 6];
        default: op_valid = ($urandom_range(0, 2) != 0);
      endcase
      op_a = va[i];
      op_b = vb[i];
      if (vmode == 2) begin
        start = ($urandom_range(0, 3) == 0);
        len   = CNT_W'($urandom_range(0, 20));
      end
      @(negedge CLK);
      f = op_valid && op_ready;
      tick();
      k++;
      if (f) i++;
    end
    op_valid = 1'b0;
    start    = 1'b0;
    if (i < n) chk("feed_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_result(input bit rnd, output logic [47:0] r);
    bit hit = 0;
    int k = 0;
    r = 'x;
    while (!hit && k < 200) begin
      if (rnd) begin
        res_ready = ($urandom_range(0, 1) != 0);
        start     = ($urandom_range(0, 3) == 0);
        len       = CNT_W'($urandom_range(0, 20));
      end
      @(negedge CLK);
      if (res_valid && res_ready) begin
        hit = 1;
        r   = res_data;
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (!hit) chk("result_timeout", 64'(k), 64'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [47:0] r;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 48'h0);
    chk("rst_opmode", dsp_opmode, 8'h08);
    chk("rst_dsp_a", dsp_a, 18'h0);
    tick();

    // Full-rate len=4.
    res_ready = 1'b1;
    vmode = 0;
    for (int i = 0; i < 4; i++) begin
      va[i] = 18'(2 * i + 1);
      vb[i] = 18'(2 * i + 2);
    end
    launch(4); feed(4); wait_result(0, r);
    chk("t1_sum", r, 48'd100);
    chk("t1_latency", 64'(last_lat), 64'd8);

    // Bubbles.
    vmode = 1;
    va[0] = 18'd10; vb[0] = 18'd10;
    va[1] = 18'd20; vb[1] = 18'd20;
    va[2] = 18'd30; vb[2] = 18'd30;
    launch(3); feed(3); wait_result(0, r);
    chk("t2_sum", r, 48'd1400);

    // Back-to-back jobs.
    vmode = 0;
    va[0] = 18'd2; vb[0] = 18'd3; va[1] = 18'd4; vb[1] = 18'd5;
    launch(2); feed(2); wait_result(0, r);
    chk("t3_sum_a", r, 48'd26);
    va[0] = 18'd7; vb[0] = 18'd7;
    launch(1); feed(1); wait_result(0, r);
    chk("t3_sum_b", r, 48'd49);

    // Zero-length job with stalled consumer.
    res_ready = 1'b0;
    launch(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t4_res_valid", res_valid, 1'b1);
      chk("t4_res_data", res_data, 48'h0);
      chk("t4_op_ready", op_ready, 1'b0);
      tick();
    end
    chk("t4_latency", 64'(last_lat), 64'd1);
    res_ready = 1'b1;
    wait_result(0, r);
    chk("t4_sum", r, 48'h0);

    // Large and negative products.
    va[0] = 18'h1FFFF; vb[0] = 18'h1FFFF; va[1] = 18'h1FFFF; vb[1] = 18'h1FFFF;
    launch(2); feed(2); wait_result(0, r);
    chk("t5_big", r, 48'h0007_FFF8_0002);
    va[0] = 18'h3FFFF; vb[0] = 18'd1; va[1] = 18'h3FFFE; vb[1] = 18'd1;
    launch(2); feed(2); wait_result(0, r);
    chk("t5_neg", r, 48'hFFFF_FFFF_FFFD);

    // Reset in the middle of a job.
    for (int i = 0; i < 5; i++) begin
      va[i] = 18'(100 + i);
      vb[i] = 18'(3);
    end
    launch(5); feed(2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_busy", busy, 1'b0);
    chk("t6_op_ready", op_ready, 1'b0);
    chk("t6_res_valid", res_valid, 1'b0);
    tick();
    va[0] = 18'd3; vb[0] = 18'd3;
    launch(1); feed(1); wait_result(0, r);
    chk("t6_sum", r, 48'd9);

    // Randomized jobs against the model.
    vmode = 2;
    for (int j = 0; j < 25; j++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) begin
        va[i] = 18'($urandom);
        vb[i] = 18'($urandom);
      end
      launch(n); feed(n); wait_result(1, r);
      res_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
